// File: rtl/ds_seq_pkg.sv
// Shared types and sizing helpers for the delta-sigma modulator sequencer.
package ds_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 24;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ds_run_detect.sv
// Run-length tracker on the modulator bitstream; flags overload when the
// count of identical consecutive bits reaches RUN_LIMIT.
module ds_run_detect
  import ds_seq_pkg::*;
#(
  parameter int RUN_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  input  logic i_bit,
  output logic o_overload
);

  localparam int RUN_W = cnt_w(RUN_LIMIT);
  localparam logic [RUN_W-1:0] LIMIT = RUN_W'(RUN_LIMIT);

  logic [RUN_W-1:0] r_run;
  logic             r_last;
  logic [RUN_W-1:0] w_run_nxt;

  // r_last mirrors the registered bitstream, so a change restarts the run at 1.
  always_comb begin
    w_run_nxt = RUN_W'(1);
    if (i_bit == r_last) begin
      w_run_nxt = (r_run == LIMIT) ? LIMIT : r_run + 1'b1;
    end
  end

  assign o_overload = i_tick && (w_run_nxt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= '0;
      r_last <= 1'b0;
    end else begin
      if (i_tick) begin
        r_last <= i_bit;
      end
      if (i_clr) begin
        r_run <= '0;
      end else if (i_tick) begin
        r_run <= w_run_nxt;
      end
    end
  end

endmodule

// File: rtl/ds_mod_sequencer.sv
// Sequencer for a 5th-order delta-sigma modulator: enable strobes, per-frame
// sample delivery through a one-entry hold, and overload clear/holdoff recovery.
module ds_mod_sequencer
  import ds_seq_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DIV           = 4,
  parameter int OSR           = 512,
  parameter int RUN_LIMIT     = 64,
  parameter int CLEAR_CYCLES  = 8,
  parameter int HOLDOFF_TICKS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] mod_in,
  output logic                     mod_enable,
  output logic                     mod_clear,
  input  logic                     bit_in,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic [7:0]               overload_cnt,
  output logic [7:0]               underrun_cnt,
  output logic                     busy
);

  localparam int DIV_W = cnt_w(DIV - 1);
  localparam int OS_W  = cnt_w(OSR - 1);
  localparam int PH_W  = cnt_w((CLEAR_CYCLES > HOLDOFF_TICKS) ? CLEAR_CYCLES : HOLDOFF_TICKS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OSR - 1);
  localparam logic [PH_W-1:0]  CLEAR_LAST = PH_W'(CLEAR_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLDOFF_TICKS - 1);
  localparam logic [7:0]       CNT_MAX    = 8'hFF;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DIV_W-1:0]         r_div_cnt;
  logic [OS_W-1:0]          r_os_cnt;
  logic [PH_W-1:0]          r_phase_cnt;
  logic signed [DATA_W-1:0] r_hold;
  logic                     r_hold_full;
  logic signed [DATA_W-1:0] r_mod_in;
  logic                     r_mod_enable;
  logic                     r_mod_clear;
  logic                     r_bit_out;
  logic                     r_bit_valid;
  logic [7:0]               r_ovl_cnt;
  logic [7:0]               r_und_cnt;

  logic w_active, w_tick, w_run_tick, w_boundary, w_accept;
  logic w_overload, w_start_go, w_load, w_consume, w_underrun;

  assign w_active   = (r_state == ST_RUN) || (r_state == ST_RECOVER);
  assign w_tick     = w_active && (r_div_cnt == DIV_LAST);
  assign w_run_tick = w_tick && (r_state == ST_RUN) && !stop;
  assign w_boundary = w_tick && (r_os_cnt == '0);
  assign w_accept   = s_valid && s_ready;
  assign w_start_go = (r_state == ST_IDLE) && start && !stop;
  // Frame work is abandoned on a tick that ends in stop or overload.
  assign w_load     = w_boundary && (r_state == ST_RUN) && !stop && !w_overload;
  assign w_consume  = w_boundary && r_hold_full && !stop && !w_overload;
  assign w_underrun = w_load && !r_hold_full;

  ds_run_detect #(
    .RUN_LIMIT (RUN_LIMIT)
  ) u_run_detect (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state != ST_RUN),
    .i_tick     (w_run_tick),
    .i_bit      (bit_in),
    .o_overload (w_overload)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_state_nxt = ST_RUN;
        ST_RUN:     if (w_overload) w_state_nxt = ST_CLEAR;
        ST_CLEAR:   if (r_phase_cnt == CLEAR_LAST) w_state_nxt = ST_RECOVER;
        ST_RECOVER: if (w_tick && (r_phase_cnt == HOLD_LAST)) w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_div_cnt    <= '0;
      r_os_cnt     <= '0;
      r_phase_cnt  <= '0;
      r_hold_full  <= 1'b0;
      r_mod_in     <= '0;
      r_mod_enable <= 1'b0;
      r_mod_clear  <= 1'b1;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_ovl_cnt    <= '0;
      r_und_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mod_enable <= w_tick && !stop && !w_overload;
      r_bit_valid  <= w_run_tick && !w_overload;
      r_mod_clear  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLEAR);

      // Held at zero outside RUN/RECOVER, so entry always starts a fresh tick period.
      if (!w_active || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (w_start_go || ((r_state == ST_RECOVER) && (w_state_nxt == ST_RUN))) begin
        r_os_cnt <= '0;
      end else if (w_tick) begin
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
      end

      if (r_state != w_state_nxt) begin
        r_phase_cnt <= '0;
      end else if ((r_state == ST_CLEAR) || ((r_state == ST_RECOVER) && w_tick)) begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end

      if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE)) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end else if (w_consume) begin
        r_hold_full <= 1'b0;
      end

      if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLEAR)) begin
        r_mod_in <= '0;
      end else if (w_load) begin
        r_mod_in <= r_hold_full ? r_hold : '0;
      end

      if (w_run_tick) begin
        r_bit_out <= bit_in;
      end

      if (w_start_go) begin
        r_ovl_cnt <= '0;
        r_und_cnt <= '0;
      end else begin
        if (w_overload && (r_ovl_cnt != CNT_MAX)) r_ovl_cnt <= r_ovl_cnt + 8'd1;
        if (w_underrun && (r_und_cnt != CNT_MAX)) r_und_cnt <= r_und_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= s_data;
    end
  end

  assign s_ready      = !r_hold_full && w_active;
  assign mod_in       = r_mod_in;
  assign mod_enable   = r_mod_enable;
  assign mod_clear    = r_mod_clear;
  assign bit_out      = r_bit_out;
  assign bit_valid    = r_bit_valid;
  assign overload_cnt = r_ovl_cnt;
  assign underrun_cnt = r_und_cnt;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ds_mod_sequencer.sv
// Randomized and directed bench for ds_mod_sequencer against a behavioural model.
module tb_ds_mod_sequencer;

  localparam int DW  = 24;
  localparam int DIV = 4;
  localparam int OSR = 8;
  localparam int RL  = 16;
  localparam int CC  = 8;
  localparam int HT  = 32;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CLEAR = 2;
  localparam int M_REC   = 3;

  logic          clk = 1'b0;
  logic          rst, start, stop, s_valid, bit_in;
  logic [DW-1:0] s_data;
  logic          s_ready, mod_enable, mod_clear, bit_out, bit_valid, busy;
  logic [DW-1:0] mod_in;
  logic [7:0]    overload_cnt, underrun_cnt;

  always #5 clk = ~clk;

  ds_mod_sequencer #(
    .DATA_W(DW), .DIV(DIV), .OSR(OSR), .RUN_LIMIT(RL),
    .CLEAR_CYCLES(CC), .HOLDOFF_TICKS(HT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mod_in(mod_in), .mod_enable(mod_enable), .mod_clear(mod_clear),
    .bit_in(bit_in), .bit_out(bit_out), .bit_valid(bit_valid),
    .overload_cnt(overload_cnt), .underrun_cnt(underrun_cnt), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Behavioural model: mode, tick phase, ticks since the frame origin, hold as a queue.
  int            m_mode, m_cyc, m_since, m_run, m_clear_left, m_holdoff, m_ovl, m_und;
  logic [DW-1:0] m_hold_q[$];
  logic [DW-1:0] m_mod_in;
  logic          m_en, m_clr, m_bout, m_bv;

  task automatic model_step();
    bit ready, accept, tick, boundary;
    if (rst) begin
      m_mode = M_IDLE; m_cyc = 0; m_since = 0; m_run = 0; m_ovl = 0; m_und = 0;
      m_hold_q.delete(); m_mod_in = '0; m_en = 0; m_clr = 1; m_bout = 0; m_bv = 0;
      return;
    end
    ready  = ((m_mode == M_RUN) || (m_mode == M_REC)) && (m_hold_q.size() == 0);
    accept = s_valid && ready;
    m_en = 0;
    m_bv = 0;
    if (stop) begin
      m_mode = M_IDLE;
      m_hold_q.delete();
      m_mod_in = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            m_mode = M_RUN; m_cyc = 0; m_since = 0; m_run = 0; m_ovl = 0; m_und = 0;
          end
        end
        M_CLEAR: begin
          m_clear_left--;
          if (m_clear_left == 0) begin
            m_mode = M_REC; m_cyc = 0; m_holdoff = 0;
          end
        end
        default: begin
          tick  = (m_cyc == DIV - 1);
          m_cyc = tick ? 0 : m_cyc + 1;
          if (tick) begin
            boundary = ((m_since % OSR) == 0);
            m_since++;
            if (m_mode == M_RUN) begin
              m_run  = (bit_in == m_bout) ? ((m_run < RL) ? m_run + 1 : RL) : 1;
              m_bout = bit_in;
              if (m_run == RL) begin
                m_mode = M_CLEAR; m_clear_left = CC; m_mod_in = '0; m_run = 0;
                if (m_ovl < 255) m_ovl++;
              end else begin
                m_en = 1;
                m_bv = 1;
                if (boundary) begin
                  if (m_hold_q.size() > 0) begin
                    m_mod_in = m_hold_q.pop_front();
                  end else begin
                    m_mod_in = '0;
                    if (m_und < 255) m_und++;
                  end
                end
              end
            end else begin
              m_en = 1;
              if (boundary && (m_hold_q.size() > 0)) void'(m_hold_q.pop_front());
              m_holdoff++;
              if (m_holdoff == HT) begin
                m_mode = M_RUN; m_since = 0; m_run = 0;
              end
            end
          end
          if (accept) m_hold_q.push_back(s_data);
        end
      endcase
    end
    m_clr = (m_mode == M_IDLE) || (m_mode == M_CLEAR);
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("s_ready", 32'(s_ready), 32'(((m_mode == M_RUN) || (m_mode == M_REC)) && (m_hold_q.size() == 0)));
    chk("mod_enable", 32'(mod_enable), 32'(m_en));
    chk("mod_clear", 32'(mod_clear), 32'(m_clr));
    chk("mod_in", 32'(mod_in), 32'(m_mod_in));
    chk("bit_out", 32'(bit_out), 32'(m_bout));
    chk("bit_valid", 32'(bit_valid), 32'(m_bv));
    chk("overload_cnt", 32'(overload_cnt), 32'(m_ovl));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
  endtask

  int bit_mode = 0;
  bit rand_valid = 1'b0;

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (rand_valid) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 24'($urandom);
    end
    case (bit_mode)
      0:       bit_in = ~bit_out;
      1:       bit_in = 1'b1;
      default: if ($urandom_range(0, 15) == 0) bit_in = ~bit_in;
    endcase
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_clear(input logic level, input string tag);
    int k;
    k = 0;
    while ((mod_clear !== level) && (k < 500)) begin
      step();
      k++;
    end
    chk(tag, 32'(mod_clear), 32'(level));
  endtask

  task automatic first_sample_scenario();
    int lat;
    rand_valid = 1'b0;
    start = 1'b1; s_valid = 1'b1; s_data = 24'h123456;
    step();
    start = 1'b0;
    chk("clear_after_start", 32'(mod_clear), 32'(0));
    step();
    s_valid = 1'b0;
    lat = 1;
    while (!mod_enable && (lat < 20)) begin
      step();
      lat++;
    end
    chk("first_enable_lat", 32'(lat), 32'(DIV));
    chk("first_mod_in", 32'(mod_in), 32'h123456);
    chk("ready_after_load", 32'(s_ready), 32'(1));
  endtask

  initial begin
    int n_en, len, k, bad_in;
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; bit_in = 1'b0;
    run_cycles(3);
    chk("rst_mod_clear", 32'(mod_clear), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    run_cycles(2);

    first_sample_scenario();
    run_cycles(31);
    chk("und_before_2nd_boundary", 32'(underrun_cnt), 32'(0));
    step();
    chk("und_at_2nd_boundary", 32'(underrun_cnt), 32'(1));
    chk("mod_in_underrun", 32'(mod_in), 32'(0));
    run_cycles(300 * OSR * DIV);
    chk("und_saturated", 32'(underrun_cnt), 32'(255));

    rand_valid = 1'b1;
    run_cycles(1000 * DIV);
    chk("alt_no_overload", 32'(overload_cnt), 32'(0));

    stop = 1'b1; step(); stop = 1'b0;
    bit_mode = 1;
    start = 1'b1; step(); start = 1'b0;
    n_en = 0; k = 0;
    while (!mod_clear && (k < 200)) begin
      step();
      k++;
      if (mod_enable) n_en++;
    end
    chk("enables_before_clear", 32'(n_en), 32'(RL - 1));
    chk("overload_once", 32'(overload_cnt), 32'(1));

    bit_mode = 0; rand_valid = 1'b0; s_valid = 1'b1; s_data = 24'hABCDEF;
    len = 1;
    while (mod_clear && (len < 50)) begin
      step();
      if (mod_clear) len++;
    end
    chk("clear_len", 32'(len), 32'(CC));
    n_en = 0; k = 0; bad_in = 0;
    while (!bit_valid && (k < 1000)) begin
      if (mod_enable) n_en++;
      if (mod_in != '0) bad_in++;
      step();
      k++;
    end
    chk("holdoff_ticks", 32'(n_en), 32'(HT));
    chk("holdoff_mod_in_zero", 32'(bad_in), 32'(0));
    chk("fresh_after_recover", 32'(mod_in), 32'hABCDEF);

    bit_mode = 1;
    wait_clear(1'b1, "enter_clear_for_stop");
    run_cycles(3);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_clear_busy", 32'(busy), 32'(0));
    chk("stop_clear_mod_clear", 32'(mod_clear), 32'(1));
    chk("stop_clear_ready", 32'(s_ready), 32'(0));
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mod_enable) n_en++;
    end
    chk("stop_clear_no_enable", 32'(n_en), 32'(0));

    bit_mode = 0;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("hold_full_ready", 32'(s_ready), 32'(0));
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_run_busy", 32'(busy), 32'(0));
    chk("stop_run_mod_clear", 32'(mod_clear), 32'(1));
    chk("stop_run_ready", 32'(s_ready), 32'(0));
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mod_enable) n_en++;
    end
    chk("stop_run_no_enable", 32'(n_en), 32'(0));

    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'(0));
    run_cycles(5);

    bit_mode = 1;
    start = 1'b1; step(); start = 1'b0;
    wait_clear(1'b1, "enter_clear_for_rst");
    wait_clear(1'b0, "enter_recover_for_rst");
    run_cycles(5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_rec_clear", 32'(mod_clear), 32'(1));
    chk("rst_rec_enable", 32'(mod_enable), 32'(0));
    chk("rst_rec_mod_in", 32'(mod_in), 32'(0));
    chk("rst_rec_bit_out", 32'(bit_out), 32'(0));
    chk("rst_rec_ovl", 32'(overload_cnt), 32'(0));
    chk("rst_rec_busy", 32'(busy), 32'(0));
    bit_mode = 0;
    step();
    first_sample_scenario();

    rand_valid = 1'b1; bit_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      step();
    end
    start = 1'b0; stop = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
